push_arbiter: RTL and testbench

- Round-robin arbiter that shares the single push port of a PushPullFIFO between NUM_PORTS producers.
- Each producer uses the same req/ack handshake the FIFO itself exposes. The arbiter grants one producer at a time, forwards its word as a one-cycle fifoReq pulse and waits for fifoAck. It then returns a one-cycle inAck to the granted producer.
- Sits directly in front of the FIFO inValue/inReq/inAck port. The FIFO pull side is untouched.

---
 rtl/push_arbiter_pkg.sv | 14 +
 rtl/rr_priority_select.sv | 40 ++++
 rtl/push_arbiter.sv | 130 +++++++++++++
 tb/tb_push_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/push_arbiter_pkg.sv
// Shared definitions for the push arbiter: FSM state encodings and logic-level constants.
package push_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first set request at or above pointer, else lowest set request.
module rr_priority_select
  import push_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int INDEX_BITS = 2
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [INDEX_BITS-1:0] pointer,
  output logic                  grant_valid,
  output logic [INDEX_BITS-1:0] grant_index
);

  logic                  hi_valid;
  logic                  lo_valid;
  logic [INDEX_BITS-1:0] hi_index;
  logic [INDEX_BITS-1:0] lo_index;

  // Upward scan from pointer with wrap is split into two ascending passes:
  // lowest hit at/above pointer wins, otherwise lowest hit overall.
  always_comb begin
    hi_valid = LOW;
    lo_valid = LOW;
    hi_index = '0;
    lo_index = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (req[j] && (INDEX_BITS'(j) >= pointer) && !hi_valid) begin
        hi_valid = HIGH;
        hi_index = INDEX_BITS'(j);
      end
      if (req[j] && !lo_valid) begin
        lo_valid = HIGH;
        lo_index = INDEX_BITS'(j);
      end
    end
    grant_valid = hi_valid | lo_valid;
    grant_index = hi_valid ? hi_index : lo_index;
  end

endmodule

// File: rtl/push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port (req/ack handshake) among NUM_PORTS producers.
module push_arbiter
  import push_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int WORD_SIZE   = 1,
  parameter int INDEX_BITS  = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] inValue,
  input  logic [NUM_PORTS-1:0]           inReq,
  output logic [NUM_PORTS-1:0]           inAck,
  output logic [WORD_SIZE-1:0]           fifoValue,
  output logic                           fifoReq,
  input  logic                           fifoAck,
  output logic [INDEX_BITS-1:0]          grantIndex,
  output logic                           busy,
  output logic                           stalled
);

  localparam int CNT_BITS = $clog2(ACK_TIMEOUT + 1);

  state_t                  state,       next_state;
  logic [NUM_PORTS-1:0]    in_ack,      next_in_ack;
  logic [WORD_SIZE-1:0]    fifo_value,  next_fifo_value;
  logic                    fifo_req,    next_fifo_req;
  logic [INDEX_BITS-1:0]   grant_index, next_grant_index;
  logic                    stall,       next_stall;
  logic [INDEX_BITS-1:0]   rr_pointer,  next_rr_pointer;
  logic [CNT_BITS-1:0]     timeout_cnt, next_timeout_cnt;

  logic                    sel_valid;
  logic [INDEX_BITS-1:0]   sel_index;
  logic [WORD_SIZE-1:0]    sel_word;

  rr_priority_select #(
    .NUM_PORTS  (NUM_PORTS),
    .INDEX_BITS (INDEX_BITS)
  ) u_select (
    .req         (inReq),
    .pointer     (rr_pointer),
    .grant_valid (sel_valid),
    .grant_index (sel_index)
  );

  always_comb begin
    sel_word = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (INDEX_BITS'(j) == sel_index) sel_word = inValue[j*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      in_ack      <= '0;
      fifo_value  <= '0;
      fifo_req    <= LOW;
      grant_index <= '0;
      stall       <= LOW;
      rr_pointer  <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= next_state;
      in_ack      <= next_in_ack;
      fifo_value  <= next_fifo_value;
      fifo_req    <= next_fifo_req;
      grant_index <= next_grant_index;
      stall       <= next_stall;
      rr_pointer  <= next_rr_pointer;
      timeout_cnt <= next_timeout_cnt;
    end
  end

  always_comb begin
    next_state       = state;
    next_in_ack      = '0;
    next_fifo_value  = fifo_value;
    next_fifo_req    = LOW;
    next_grant_index = grant_index;
    next_stall       = stall;
    next_rr_pointer  = rr_pointer;
    next_timeout_cnt = timeout_cnt;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          next_grant_index = sel_index;
          next_fifo_value  = sel_word;
          next_fifo_req    = HIGH;
          next_state       = ISSUE;
        end
      end
      ISSUE: begin
        next_timeout_cnt = '0;
        next_state       = WAIT;
      end
      WAIT: begin
        if (fifoAck) begin
          for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            next_in_ack[j] = (INDEX_BITS'(j) == grant_index);
          end
          next_rr_pointer = (grant_index == INDEX_BITS'(NUM_PORTS - 1)) ? '0 : grant_index + 1'b1;
          next_stall      = LOW;
          next_state      = RELEASE;
        end else if (timeout_cnt == CNT_BITS'(ACK_TIMEOUT - 1)) begin
          // Retry with the latched word; the FIFO is never given up on.
          next_stall    = HIGH;
          next_fifo_req = HIGH;
          next_state    = ISSUE;
        end else begin
          next_timeout_cnt = timeout_cnt + 1'b1;
        end
      end
      RELEASE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign inAck      = in_ack;
  assign fifoValue  = fifo_value;
  assign fifoReq    = fifo_req;
  assign grantIndex = grant_index;
  assign stalled    = stall;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_push_arbiter.sv
// Directed bench for push_arbiter: table of transfers plus stall, spurious-ack, reset and FIFO-integration sequences.
module tb_push_arbiter;

  logic       clock;
  logic       clear;
  logic [3:0] inValue;
  logic [3:0] inReq;
  logic [3:0] inAck;
  logic [0:0] fifoValue;
  logic       fifoReq;
  logic       fifoAck;
  logic [1:0] grantIndex;
  logic       busy;
  logic       stalled;

  logic       auto_ack;
  logic       spur_ack;
  logic       model_ack;
  logic       fifo_en;
  logic       prev_req;
  logic       fifo_q[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] val;
    logic [1:0] grant;
    logic       word;
  } vec_t;

  vec_t tbl[17];

  push_arbiter #(
    .NUM_PORTS   (4),
    .WORD_SIZE   (1),
    .INDEX_BITS  (2),
    .ACK_TIMEOUT (8)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .inValue    (inValue),
    .inReq      (inReq),
    .inAck      (inAck),
    .fifoValue  (fifoValue),
    .fifoReq    (fifoReq),
    .fifoAck    (fifoAck),
    .grantIndex (grantIndex),
    .busy       (busy),
    .stalled    (stalled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign fifoAck = model_ack | spur_ack;

  // FIFO push-side model: acks the cycle after a request, queues words when enabled.
  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      model_ack <= 1'b0;
      fifo_q.delete();
    end else begin
      model_ack <= auto_ack & fifoReq;
      if (auto_ack && fifoReq && fifo_en && fifo_q.size() < 4) fifo_q.push_back(fifoValue[0]);
    end
  end

  always @(negedge clock) begin
    if (clear) begin
      checks++;
      if (!$onehot0(inAck)) begin
        errors++;
        $display("FAIL inack_onehot: got %b required at most one bit", inAck);
      end
      checks++;
      if (fifoReq && prev_req) begin
        errors++;
        $display("FAIL fifoReq_back_to_back: got two consecutive high cycles required single pulse");
      end
    end
    prev_req <= fifoReq;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fifoReq"},    32'(fifoReq),    0);
    check({tag, "_fifoValue"},  32'(fifoValue),  0);
    check({tag, "_grantIndex"}, 32'(grantIndex), 0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_stalled"},    32'(stalled),    0);
    check({tag, "_inAck"},      32'(inAck),      0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One transfer with an auto-acking FIFO; called #1 after an edge while the DUT is in IDLE.
  task automatic transfer(input vec_t v);
    logic [3:0] ack_mask;
    ack_mask = 4'b0001 << v.grant;
    inReq   = v.req;
    inValue = v.val;
    step();
    check("issue_fifoReq", 32'(fifoReq),    1);
    check("issue_grant",   32'(grantIndex), 32'(v.grant));
    check("issue_word",    32'(fifoValue),  32'(v.word));
    check("issue_busy",    32'(busy),       1);
    inValue = ~inValue;
    step();
    check("wait_fifoReq",  32'(fifoReq),    0);
    check("wait_inAck",    32'(inAck),      0);
    check("wait_word",     32'(fifoValue),  32'(v.word));
    step();
    check("ack_inAck",     32'(inAck),      32'(ack_mask));
    check("ack_stalled",   32'(stalled),    0);
    inReq = inReq & ~ack_mask;
    step();
    check("release_inAck", 32'(inAck),      0);
    check("release_busy",  32'(busy),       0);
  endtask

  initial begin
    logic exp_pull[4];
    logic exp_req;
    logic exp_stall;
    logic [3:0] exp_ack;

    //          req      val      grant word
    tbl[0]  = '{4'b1111, 4'b1101, 2'd0, 1'b1};
    tbl[1]  = '{4'b1110, 4'b1101, 2'd1, 1'b0};
    tbl[2]  = '{4'b1100, 4'b1101, 2'd2, 1'b1};
    tbl[3]  = '{4'b1000, 4'b1101, 2'd3, 1'b1};
    tbl[4]  = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b1001, 4'b0000, 2'd3, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1000, 2'd0, 1'b0};
    tbl[7]  = '{4'b1001, 4'b1001, 2'd3, 1'b1};
    tbl[8]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[9]  = '{4'b0010, 4'b0000, 2'd1, 1'b0};
    tbl[10] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{4'b0010, 4'b1101, 2'd1, 1'b0};
    tbl[12] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[13] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
    tbl[14] = '{4'b0011, 4'b0000, 2'd1, 1'b0};
    tbl[15] = '{4'b0011, 4'b0010, 2'd0, 1'b0};
    tbl[16] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
    exp_pull = '{1'b1, 1'b0, 1'b0, 1'b1};

    clear    = 1'b1;
    inReq    = '0;
    inValue  = '0;
    auto_ack = 1'b1;
    spur_ack = 1'b0;
    fifo_en  = 1'b0;
    #2 clear = 1'b0;
    #1 check_reset("por");
    step();
    check_reset("por_held");
    clear = 1'b1;

    // All ports, fairness/wrap, single producer
    for (int i = 0; i < 12; i++) transfer(tbl[i]);

    // Stall: pointer is 2, port 2 requests, FIFO silent for 20 cycles then acks
    auto_ack = 1'b0;
    inReq    = 4'b0100;
    inValue  = 4'b0100;
    for (int c = 0; c < 32; c++) begin
      step();
      exp_req   = (c == 0) || (c == 9) || (c == 18) || (c == 27);
      exp_stall = (c >= 9) && (c < 29);
      exp_ack   = (c == 29) ? 4'b0100 : 4'b0000;
      check("stall_fifoReq", 32'(fifoReq), 32'(exp_req));
      check("stall_flag",    32'(stalled), 32'(exp_stall));
      check("stall_inAck",   32'(inAck),   32'(exp_ack));
      check("stall_busy",    32'(busy),    (c < 30) ? 1 : 0);
      if (c <= 29) check("stall_word", 32'(fifoValue), 1);
      if (c == 0) inValue = 4'b0000;
      if (c == 19) auto_ack = 1'b1;
      if (c == 29) inReq = 4'b0000;
    end

    // Spurious acks outside WAIT, producer drops inReq early; pointer is 3
    auto_ack = 1'b0;
    spur_ack = 1'b1;
    step();
    check("spur_idle_busy",  32'(busy),  0);
    check("spur_idle_inAck", 32'(inAck), 0);
    spur_ack = 1'b0;
    inReq    = 4'b1000;
    inValue  = 4'b1000;
    step();
    check("spur_grant",   32'(grantIndex), 3);
    check("spur_fifoReq", 32'(fifoReq),    1);
    inReq    = 4'b0000;
    spur_ack = 1'b1;
    step();
    spur_ack = 1'b0;
    check("spur_issue_inAck", 32'(inAck), 0);
    check("spur_issue_busy",  32'(busy),  1);
    step();
    check("spur_wait_inAck", 32'(inAck), 0);
    spur_ack = 1'b1;
    step();
    spur_ack = 1'b0;
    check("drop_req_inAck", 32'(inAck), 32'(4'b1000));
    step();
    check("drop_req_idle", 32'(busy), 0);

    // Reset in WAIT, then port 2 wins first
    inReq   = 4'b0001;
    inValue = 4'b0001;
    step();
    step();
    check("pre_reset_busy", 32'(busy), 1);
    clear = 1'b0;
    #1 check_reset("mid_reset");
    inReq = '0;
    step();
    check("reset_hold_inAck", 32'(inAck), 0);
    clear    = 1'b1;
    auto_ack = 1'b1;
    transfer(tbl[12]);

    // FIFO integration from a fresh reset
    clear = 1'b0;
    step();
    clear   = 1'b1;
    fifo_en = 1'b1;
    for (int i = 13; i < 17; i++) transfer(tbl[i]);
    check("fifo_depth", 32'(fifo_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < fifo_q.size()) check("fifo_pull", 32'(fifo_q[i]), 32'(exp_pull[i]));
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
